// File: rtl/mips32_mem_pkg.sv
// mips32_mem_pkg -- shared definitions for the mips32 data-memory responder.
//   WORD_W               : data word width
//   SZ_BYTE/SZ_HALF/...  : m_size encodings (2'b11 is treated as a word)
//   dmem_state_e         : responder FSM states
package mips32_mem_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } dmem_state_e;

endpackage

// File: rtl/mips32_dmem_lane.sv
// mips32_dmem_lane -- combinational little-endian lane steering.
// Ports:
//   off_i        : byte offset inside the word (already aligned for the size)
//   size_i       : access size (SZ_BYTE / SZ_HALF / word for anything else)
//   sign_i       : 1 = sign-extend load data, 0 = zero-extend
//   old_word_i   : current contents of the addressed word
//   st_data_i    : right-aligned store data
//   merged_o     : old word with the addressed lanes replaced by store data
//   load_o       : addressed lanes shifted to bit 0 and extended
module mips32_dmem_lane
  import mips32_mem_pkg::*;
(
  input  logic [1:0]        off_i,
  input  logic [1:0]        size_i,
  input  logic              sign_i,
  input  logic [WORD_W-1:0] old_word_i,
  input  logic [WORD_W-1:0] st_data_i,
  output logic [WORD_W-1:0] merged_o,
  output logic [WORD_W-1:0] load_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = old_word_i[{off_i, 3'b000} +: 8];
  assign half_v = old_word_i[{off_i[1], 4'b0000} +: 16];

  always_comb begin
    merged_o = old_word_i;
    load_o   = old_word_i;
    case (size_i)
      SZ_BYTE: begin
        merged_o[{off_i, 3'b000} +: 8] = st_data_i[7:0];
        load_o = sign_i ? {{24{byte_v[7]}}, byte_v} : {24'h000000, byte_v};
      end
      SZ_HALF: begin
        merged_o[{off_i[1], 4'b0000} +: 16] = st_data_i[15:0];
        load_o = sign_i ? {{16{half_v[15]}}, half_v} : {16'h0000, half_v};
      end
      default: begin
        merged_o = st_data_i;
        load_o   = old_word_i;
      end
    endcase
  end

endmodule

// File: rtl/mips32_dmem_responder.sv
// mips32_dmem_responder -- MEM-stage data memory with programmable wait states.
// Accepts one load/store at a time, holds the pipeline with m_stall_o, and
// pulses m_done_o when the access completes.
// Parameters: ADDR_W (word-address bits), WAIT_CYCLES (0..15 wait states).
// Ports:
//   clk_i, rst_i (async, active-high)
//   m_read_i, m_write_i (store wins), m_addr_i (byte address), m_size_i,
//   m_sign_i, m_din_i  -> request
//   m_dout_o (load data), m_stall_o, m_done_o, m_err_o -> response
// Build option: MIPS32_DMEM_ALIGN_CHECK_EN reports misaligned halfword/word
// accesses on m_err_o (store suppressed, load returns 0). Without it the low
// address bits are forced to alignment and m_err_o is tied low.
module mips32_dmem_responder
  import mips32_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m_read_i,
  input  logic              m_write_i,
  input  logic [31:0]       m_addr_i,
  input  logic [1:0]        m_size_i,
  input  logic              m_sign_i,
  input  logic [WORD_W-1:0] m_din_i,
  output logic [WORD_W-1:0] m_dout_o,
  output logic              m_stall_o,
  output logic              m_done_o,
  output logic              m_err_o
);

  dmem_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q;
  logic [1:0]        off_q, size_q;
  logic              sign_q, wr_q, err_q;
  logic [WORD_W-1:0] din_q, dout_q;

  logic [WORD_W-1:0] mem [2**ADDR_W];

  logic              req, is_idle;
  logic [ADDR_W-1:0] in_idx, cur_idx;
  logic [1:0]        in_off, cur_off, cur_size;
  logic              in_err, cur_sign, cur_wr, cur_err;
  logic [WORD_W-1:0] cur_din, merged, load_val;
  logic              unused_addr;

  assign unused_addr = ^{m_addr_i[31:ADDR_W+2]};

  assign req     = m_read_i | m_write_i;
  assign is_idle = (state_q == ST_IDLE);
  assign in_idx  = m_addr_i[ADDR_W+1:2];

  // Offset is forced to the natural alignment of the size; with the check
  // enabled a misaligned access is flagged and its data path is discarded.
  always_comb begin
    case (m_size_i)
      SZ_BYTE: in_off = m_addr_i[1:0];
      SZ_HALF: in_off = {m_addr_i[1], 1'b0};
      default: in_off = 2'b00;
    endcase
  end

`ifdef MIPS32_DMEM_ALIGN_CHECK_EN
  always_comb begin
    case (m_size_i)
      SZ_BYTE: in_err = 1'b0;
      SZ_HALF: in_err = m_addr_i[0];
      default: in_err = (m_addr_i[1:0] != 2'b00);
    endcase
  end
`else
  assign in_err = 1'b0;
`endif

  // In IDLE the request inputs are live (needed when WAIT_CYCLES is 0 and the
  // load result is registered on the same edge that accepts the request).
  assign cur_idx  = is_idle ? in_idx    : idx_q;
  assign cur_off  = is_idle ? in_off    : off_q;
  assign cur_size = is_idle ? m_size_i  : size_q;
  assign cur_sign = is_idle ? m_sign_i  : sign_q;
  assign cur_din  = is_idle ? m_din_i   : din_q;
  assign cur_wr   = is_idle ? m_write_i : wr_q;
  assign cur_err  = is_idle ? in_err    : err_q;

  mips32_dmem_lane u_lane (
    .off_i      (cur_off),
    .size_i     (cur_size),
    .sign_i     (cur_sign),
    .old_word_i (mem[cur_idx]),
    .st_data_i  (cur_din),
    .merged_o   (merged),
    .load_o     (load_val)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      din_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (is_idle && req) begin
        idx_q  <= in_idx;
        off_q  <= in_off;
        size_q <= m_size_i;
        sign_q <= m_sign_i;
        wr_q   <= m_write_i;
        err_q  <= in_err;
        din_q  <= m_din_i;
      end
      if ((state_d == ST_DONE) && (state_q != ST_DONE) && !cur_wr)
        dout_q <= cur_err ? '0 : load_val;
    end
  end

  // Array is not reset; the store commits on the DONE->IDLE edge, so a reset
  // anywhere before that edge drops it.
  always_ff @(posedge clk_i) begin
    if ((state_q == ST_DONE) && wr_q && !err_q)
      mem[idx_q] <= merged;
  end

  assign m_dout_o  = dout_q;
  assign m_stall_o = (is_idle && req) || (state_q == ST_WAIT);
  assign m_done_o  = (state_q == ST_DONE);
  assign m_err_o   = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_mips32_dmem_responder.sv
module tb_mips32_dmem_responder;

  localparam int WAIT = 2;
  localparam int MAXW = 40;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        m_read_i = 1'b0, m_write_i = 1'b0, m_sign_i = 1'b0;
  logic [31:0] m_addr_i = '0, m_din_i = '0;
  logic [1:0]  m_size_i = '0;
  logic [31:0] m_dout_o;
  logic        m_stall_o, m_done_o, m_err_o;

  int vectors = 0;
  int miscompares = 0;

  // byte-addressed reference memory covering one alias window (4096 bytes)
  logic [7:0]  mb [4096];
  logic [31:0] model_dout = '0;
  bit          start_in_done = 0;

  mips32_dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(WAIT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .m_read_i(m_read_i), .m_write_i(m_write_i),
    .m_addr_i(m_addr_i), .m_size_i(m_size_i), .m_sign_i(m_sign_i),
    .m_din_i(m_din_i), .m_dout_o(m_dout_o), .m_stall_o(m_stall_o),
    .m_done_o(m_done_o), .m_err_o(m_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_op(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                          input bit sgn, input logic [31:0] din,
                          output logic [31:0] exp_dout, output bit exp_err);
    int n, a;
    logic [63:0] v;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    a = int'(addr[11:0]);
    exp_err = 0;
`ifdef MIPS32_DMEM_ALIGN_CHECK_EN
    exp_err = (a % n) != 0;
`endif
    a = a - (a % n);
    if (wr) begin
      if (!exp_err)
        for (int i = 0; i < n; i++) mb[a + i] = din[8*i +: 8];
    end else if (exp_err) begin
      model_dout = '0;
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (64'(mb[a + i]) << (8 * i));
      if (sgn && v[8*n-1]) v = v | (~64'd0 << (8 * n));
      model_dout = v[31:0];
    end
    exp_dout = model_dout;
  endtask

  // Called at a negedge (or just after). Runs one access, checks latency,
  // stall duration, error flag and load data against the model.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [1:0] size, input bit sgn, input logic [31:0] din,
                        input bit gap, input string nm, output logic [31:0] got);
    logic [31:0] exp_dout;
    bit exp_err, seen;
    int k, stall_n, exp_k;
    model_op(wr, addr, size, sgn, din, exp_dout, exp_err);
    m_read_i = rd; m_write_i = wr; m_addr_i = addr; m_size_i = size;
    m_sign_i = sgn; m_din_i = din;
    exp_k = WAIT + 1 + (start_in_done ? 1 : 0);
    k = 0; stall_n = 0; seen = 0;
    while (k <= MAXW) begin
      #1;
      if (m_stall_o) stall_n++;
      if (m_done_o && !(k == 0 && start_in_done)) begin seen = 1; break; end
      @(negedge clk_i);
      k++;
    end
    vectors++;
    if (!seen || k !== exp_k) begin
      miscompares++;
      $display("FAIL %s latency: got %0d cycles (seen=%0d), required %0d", nm, k, seen, exp_k);
    end
    vectors++;
    if (stall_n !== WAIT + 1) begin
      miscompares++;
      $display("FAIL %s stall_cycles: got %0d, required %0d", nm, stall_n, WAIT + 1);
    end
    vectors++;
    if (m_err_o !== exp_err) begin
      miscompares++;
      $display("FAIL %s err: got %0b, required %0b", nm, m_err_o, exp_err);
    end
    vectors++;
    if (m_dout_o !== exp_dout) begin
      miscompares++;
      $display("FAIL %s dout: got %h, required %h", nm, m_dout_o, exp_dout);
    end
    got = m_dout_o;
    if (gap) begin
      m_read_i = 0; m_write_i = 0;
      @(negedge clk_i); #1;
      vectors++;
      if (m_done_o !== 1'b0 || m_stall_o !== 1'b0) begin
        miscompares++;
        $display("FAIL %s after_done: done=%0b stall=%0b, required 0 0", nm, m_done_o, m_stall_o);
      end
      start_in_done = 0;
    end else begin
      start_in_done = 1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk_i); #1;
    vectors++;
    if ({m_dout_o, m_stall_o, m_done_o, m_err_o} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: dout=%h stall=%0b done=%0b err=%0b, required all 0",
               m_dout_o, m_stall_o, m_done_o, m_err_o);
    end
    @(negedge clk_i); rst_i = 0;
  endtask

  task automatic test_preload();
    logic [31:0] g;
    for (int w = 0; w < 40; w++)
      access(0, 1, 32'(w * 4), 2'b10, 0, $urandom, 1, "preload", g);
  endtask

  task automatic test_word_store_load();
    logic [31:0] g;
    access(0, 1, 32'h40, 2'b10, 0, 32'hDEADBEEF, 1, "word_store", g);
    access(1, 0, 32'h40, 2'b10, 0, 32'h0, 1, "word_load", g);
    vectors++;
    if (g !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL word_load_const: got %h, required deadbeef", g);
    end
  endtask

  task automatic test_byte_sign();
    logic [31:0] g;
    access(1, 0, 32'h43, 2'b00, 1, 32'h0, 1, "byte_sext", g);
    vectors++;
    if (g !== 32'hFFFFFFDE) begin
      miscompares++;
      $display("FAIL byte_sext_const: got %h, required ffffffde", g);
    end
    access(1, 0, 32'h43, 2'b00, 0, 32'h0, 1, "byte_zext", g);
    vectors++;
    if (g !== 32'h000000DE) begin
      miscompares++;
      $display("FAIL byte_zext_const: got %h, required 000000de", g);
    end
  endtask

  task automatic test_half_store();
    logic [31:0] g;
    access(0, 1, 32'h42, 2'b01, 0, 32'hFFFF1234, 1, "half_store", g);
    access(1, 0, 32'h40, 2'b10, 0, 32'h0, 1, "half_word_load", g);
    vectors++;
    if (g !== 32'h1234BEEF) begin
      miscompares++;
      $display("FAIL half_merge_const: got %h, required 1234beef", g);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] g, exp;
    bit err_seen;
    access(1, 0, 32'h41, 2'b10, 0, 32'h0, 0, "misaligned_load", g);
    err_seen = m_err_o;
`ifdef MIPS32_DMEM_ALIGN_CHECK_EN
    exp = 32'h0;
`else
    exp = 32'h1234BEEF;
`endif
    vectors++;
    if (g !== exp) begin
      miscompares++;
      $display("FAIL misaligned_dout_const: got %h, required %h", g, exp);
    end
    // store to a misaligned word: suppressed with the check, aligned without it
    access(0, 1, 32'h46, 2'b10, 0, 32'h0BADF00D, 1, "misaligned_store", g);
    access(1, 0, 32'h44, 2'b10, 0, 32'h0, 1, "misaligned_store_rb", g);
    vectors++;
    if (err_seen === 1'bx) begin
      miscompares++;
      $display("FAIL misaligned_err_known: got x, required 0 or 1");
    end
  endtask

  task automatic test_alias();
    logic [31:0] g;
    access(0, 1, 32'h1000, 2'b10, 0, 32'hA5A5A5A5, 1, "alias_store", g);
    access(1, 0, 32'h0000, 2'b10, 0, 32'h0, 1, "alias_load", g);
    vectors++;
    if (g !== 32'hA5A5A5A5) begin
      miscompares++;
      $display("FAIL alias_const: got %h, required a5a5a5a5", g);
    end
  endtask

  task automatic test_reset_mid_store();
    logic [31:0] g, dummy;
    bit dummy_err;
    access(1, 0, 32'h80, 2'b10, 0, 32'h0, 1, "pre_reset_load", g);
    m_read_i = 0; m_write_i = 1; m_addr_i = 32'h80; m_size_i = 2'b10;
    m_din_i = 32'h5A5A1234;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1; m_write_i = 0;
    #1;
    vectors++;
    if ({m_dout_o, m_stall_o, m_done_o, m_err_o} !== 35'd0) begin
      miscompares++;
      $display("FAIL midreset_outputs: dout=%h stall=%0b done=%0b err=%0b, required all 0",
               m_dout_o, m_stall_o, m_done_o, m_err_o);
    end
    model_dout = '0;
    @(negedge clk_i); rst_i = 0;
    @(negedge clk_i); #1;
    vectors++;
    if (m_done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_no_done: done=%0b, required 0", m_done_o);
    end
    dummy = '0; dummy_err = 0;
    access(1, 0, 32'h80, 2'b10, 0, 32'h0, 1, "post_reset_load", dummy);
    vectors++;
    if (dummy !== g) begin
      miscompares++;
      $display("FAIL midreset_store_dropped: got %h, required %h", dummy, g);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] g;
    access(0, 1, 32'h10, 2'b10, 0, 32'hCAFEF00D, 0, "b2b_0", g);
    access(1, 0, 32'h12, 2'b01, 1, 32'h0, 0, "b2b_1", g);
    access(0, 1, 32'h11, 2'b00, 0, 32'h77, 0, "b2b_2", g);
    access(1, 0, 32'h10, 2'b10, 0, 32'h0, 1, "b2b_3", g);
    vectors++;
    if (g !== 32'hCAFE770D) begin
      miscompares++;
      $display("FAIL b2b_const: got %h, required cafe770d", g);
    end
  endtask

  task automatic test_random();
    logic [31:0] g, addr;
    bit wr, rd;
    for (int i = 0; i < 80; i++) begin
      wr = ($urandom_range(0, 2) == 0);
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      addr = {$urandom_range(0, 15) == 0 ? 20'($urandom) : 20'h0,
              10'($urandom_range(0, 39)), 2'($urandom)};
      access(rd, wr, addr, 2'($urandom), 1'($urandom), $urandom,
             1'($urandom_range(0, 3) != 0), "random", g);
    end
    if (start_in_done) begin
      m_read_i = 0; m_write_i = 0;
      @(negedge clk_i);
      start_in_done = 0;
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_word_store_load();
    test_byte_sign();
    test_half_store();
    test_misaligned();
    test_alias();
    test_reset_mid_store();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mips32_dmem_responder.md
# mips32_dmem_responder

Data-memory responder for the mips32 pipeline's MEM stage: the memory-side end of the `m_read`/`m_write`/`m_addr`/`m_din`/`m_dout` interface. It accepts one load or store at a time and holds the MEM stage with `m_stall` for a programmable number of wait states. It performs little-endian byte, halfword and word lane handling, with sign or zero extension on loads. It replaces a zero-latency RAM so the pipeline's stall path is exercised with realistic memory timing.

## Interface
- `ADDR_W`, 10, word-address bits; storage is 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, 2, wait states inserted between request acceptance and completion (0..15).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `m_read`  in  1  load request.
- `m_write`  in  1  store request; takes priority when asserted together with `m_read`.
- `m_addr`  in  32  byte address.
- `m_size`  in  2  access size: 00 byte, 01 halfword, 10 word; 11 is treated as word.
- `m_sign`  in  1  sign-extend load data when 1, zero-extend when 0.
- `m_din`  in  32  store data, right-aligned.
- `m_dout`  out  32  load data, right-aligned and extended.
- `m_stall`  out  1  request pending; the MEM stage must hold its request.
- `m_done`  out  1  one-cycle pulse when an access completes.
- `m_err`  out  1  misaligned access; qualified by `m_done`.

## Operation
- The FSM has three states: IDLE, WAIT and DONE.
- **IDLE.** When `m_read|m_write` is high, latch `m_addr`, `m_size`, `m_sign`, `m_din` and the request type.
  - Load the wait counter with `WAIT_CYCLES`.
  - Go to WAIT, or go directly to DONE if `WAIT_CYCLES`=0.
- **WAIT.** Decrement the counter each cycle. When the counter reaches 1, go to DONE on that edge.
- **DONE.** Assert `m_done` for one cycle, then return to IDLE.
  - A store commits to the array on the DONE→IDLE edge.
  - Load data is registered on the WAIT/IDLE→DONE edge.
- `m_stall` is combinational. It is high in IDLE while a request is present, and high throughout WAIT. It is low in DONE.
- The requester holds its inputs stable while `m_stall`=1. Inputs are not sampled again until IDLE.
- **Address mapping.** The word index is `m_addr[ADDR_W+1:2]`. Upper address bits are ignored, so the array aliases and wraps modulo 2^(ADDR_W+2) bytes.
- **Byte lanes.** Byte k occupies bits [8k+7:8k]. A halfword at offset 2 occupies bits [31:16].
- **Stores.** Only the addressed lanes are written. Other bytes of the word are preserved via read-modify-write of the latched word.
- **Loads.** The selected lane(s) are shifted to bit 0. The result is extended per `m_sign`.
- `m_dout` holds its value until the next load completes. Stores do not change `m_dout`.

## Timing
- **Reset values.** State IDLE, counter 0, `m_dout`=0, `m_done`=0, `m_err`=0. `m_stall` follows the rule above (0 with no request).
- Array contents are not reset.
- **Latency.** A request seen in IDLE at cycle 0 produces `m_done` at cycle `WAIT_CYCLES`+1. `m_stall` is high for cycles 0..`WAIT_CYCLES`.
- **Back-to-back.** The pipeline advances on the DONE edge. A new request is accepted in the following IDLE cycle, giving a throughput of one access per `WAIT_CYCLES`+2 cycles.
- **Reset mid-operation.** The access is abandoned, a pending store is not committed, and no `m_done` is produced.
- **Store then load to the same word.** The load observes the stored data.

## Configuration
- `MIPS32_DMEM_ALIGN_CHECK_EN` defined:
  - A halfword with `m_addr[0]`=1, or a word with `m_addr[1:0]`≠0, still completes with normal latency.
  - `m_done`=1 and `m_err`=1; the store is suppressed and `m_dout` loads 0.
- Undefined:
  - The low address bits are forced to alignment: bit 0 is cleared for a halfword, bits [1:0] for a word.
  - `m_err` is tied 0.

## Structure
- Shared package `mips32_mem_pkg` holds:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - FSM state encodings;
  - width constant `WORD_W`=32.
- The sub-module `mips32_dmem_lane` is combinational. It takes offset, size, sign, the old word and the store data, and produces the merged store word and the extended load value.
- The FSM, counter and storage array live in the top.

## Test plan
- **Word store, then load.** Word store 0xDEADBEEF to 0x40, then word load 0x40 → `m_dout`=0xDEADBEEF; `m_done` exactly 3 cycles after each request (`WAIT_CYCLES`=2); `m_stall` high for 3 cycles.
- **Byte load, sign-extended.** After the above, byte load 0x43 with `m_sign`=1 → 0xFFFFFFDE; with `m_sign`=0 → 0x000000DE.
- **Halfword store, then word load.** Halfword store 0x1234 to 0x42, then word load 0x40 → 0x1234BEEF.
- **Misaligned word load to 0x41.** With `MIPS32_DMEM_ALIGN_CHECK_EN`: `m_err`=1 with `m_done` and `m_dout`=0. Without it: `m_err`=0 and `m_dout` equals the word load of 0x40.
- **Aliasing.** With `ADDR_W`=10, a word store of 0xA5A5A5A5 to 0x1000 is read back by a word load from 0x0000.
- **Reset during a store.** Assert `rst` during WAIT of a store to 0x80 → outputs return to reset values immediately, and a later load of 0x80 returns the previous contents.
